// File: rtl/gf2p4_pkg.sv
// Shared constants and types for the GF(2^4) divider over x^4+x+1.
// Step count is the exponent of B in A*B^14 = A/B.
package gf2p4_pkg;

    localparam logic [4:0] GF2P4_POLY = 5'b10011;
    localparam int GF2P4_DIV_STEPS = 14;
    localparam logic [3:0] GF2P4_LAST_STEP = 4'(GF2P4_DIV_STEPS - 1);

    typedef logic [3:0] nibble_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/gf2p4_mult.sv
// Combinational GF(2^4) multiplier: carry-less product reduced
// modulo GF2P4_POLY.
module gf2p4_mult
    import gf2p4_pkg::*;
(
    input  nibble_t a,
    input  nibble_t b,
    output nibble_t p
);

    logic [6:0] prod;

    always_comb begin
        prod = '0;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) prod = prod ^ ({3'b000, a} << i);
        end
        // Fold bits 6..4 back in, highest first.
        for (int i = 6; i >= 4; i--) begin
            if (prod[i]) prod = prod ^ ({2'b00, GF2P4_POLY} << (i - 4));
        end
        p = prod[3:0];
    end

endmodule

// File: rtl/gf2p4_divider.sv
// Sequential GF(2^4) divider: O = A * B^14 with one multiply per cycle.
// Define GF2P4_DIV_ERR_EN to expose the div_zero flag.
module gf2p4_divider
    import gf2p4_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    in_valid,
    output logic    in_ready,
    input  nibble_t A,
    input  nibble_t B,
    output logic    out_valid,
    input  logic    out_ready,
    output nibble_t O
`ifdef GF2P4_DIV_ERR_EN
    ,
    output logic    div_zero
`endif
);

    state_t  state;
    nibble_t acc;
    nibble_t b_q;
    nibble_t prod;
    logic [3:0] cnt;

`ifndef GF2P4_DIV_ERR_EN
    logic div_zero;
`endif

    gf2p4_mult u_mult (
        .a(acc),
        .b(b_q),
        .p(prod)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            b_q       <= '0;
            cnt       <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            O         <= '0;
            div_zero  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        b_q      <= B;
                        acc      <= A;
                        cnt      <= '0;
                        // B = 0 has no inverse: skip RUN and report zero.
                        if (B == '0) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            O         <= '0;
                            div_zero  <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    acc <= prod;
                    cnt <= cnt + 4'd1;
                    if (cnt == GF2P4_LAST_STEP) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        O         <= prod;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        div_zero  <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifndef GF2P4_DIV_ERR_EN
    logic unused_dz;
    assign unused_dz = div_zero;
`endif

endmodule
